// File: rtl/roe_pkg.sv
// Shared widths and types for the register-file write arbiter.
package roe_pkg;
  localparam int DW = 8;
  localparam int IW = 2;
  localparam int PW = 2;
  localparam int CW = 8;

  typedef enum logic {
    REQ_ALU  = 1'b0,
    REQ_LOAD = 1'b1
  } req_id_t;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
  } wr_req_t;
endpackage

// File: rtl/rr_arb2.sv
// 2-way round-robin picker returning a one-hot grant; the winner is whoever did not win last.
// Latency: combinational. Backpressure: a requester that is not granted simply sees no grant.
module rr_arb2
  import roe_pkg::*;
(
  input  logic [1:0] valid,
  input  req_id_t    last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (valid[0] && (!valid[1] || last_grant == REQ_LOAD)) begin
      grant[0] = 1'b1;
    end else if (valid[1]) begin
      grant[1] = 1'b1;
    end
  end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Shares the register-file write port between ALU and load writeback and owns the play-area bank.
// Latency: 1 cycle from grant to rf_we. Backpressure: the losing requester holds until its ready.
module rf_wr_arbiter
  import roe_pkg::*;
#(
  parameter int DW = roe_pkg::DW,
  parameter int IW = roe_pkg::IW,
  parameter int PW = roe_pkg::PW,
  parameter int CW = roe_pkg::CW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PW:0]      set_pa,
  input  logic             req0_valid,
  input  logic [IW-1:0]    req0_idx,
  input  logic [DW-1:0]    req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [IW-1:0]    req1_idx,
  input  logic [DW-1:0]    req1_data,
  output logic             req1_ready,
  output logic             rf_we,
  output logic [PW+IW-1:0] rf_waddr,
  output logic [DW-1:0]    rf_wdata,
  output logic [PW-1:0]    cur_pa,
  output logic             alu_stall,
  output logic [CW-1:0]    wait_cnt
);

  req_id_t       last_grant;
  logic [1:0]    grant;
  logic [PW-1:0] pa_eff;
  logic          stall_any;
  wr_req_t       sel;

  rr_arb2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Ready is suppressed while reset is held so nothing is consumed that would be dropped.
  assign req0_ready = grant[0] & ~reset;
  assign req1_ready = grant[1] & ~reset;
  assign alu_stall  = req0_valid & ~req0_ready;
  assign stall_any  = alu_stall | (req1_valid & ~req1_ready);

  // A PA update in the same cycle as a grant is bypassed into the write address.
  assign pa_eff = set_pa[PW] ? set_pa[PW-1:0] : cur_pa;

  always_comb begin
    sel.idx  = req0_idx;
    sel.data = req0_data;
    if (grant[1]) begin
      sel.idx  = req1_idx;
      sel.data = req1_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      cur_pa     <= '0;
      last_grant <= REQ_LOAD;
      wait_cnt   <= '0;
    end else begin
      rf_we <= |grant;
      if (|grant) begin
        rf_waddr   <= {pa_eff, sel.idx};
        rf_wdata   <= sel.data;
        last_grant <= grant[1] ? REQ_LOAD : REQ_ALU;
      end
      if (set_pa[PW]) begin
        cur_pa <= set_pa[PW-1:0];
      end
      if (stall_any && wait_cnt != '1) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Scenario bench for rf_wr_arbiter: writes are scoreboarded, handshakes and counters checked inline.
module tb_rf_wr_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] set_pa;
  logic       req0_valid, req1_valid;
  logic [1:0] req0_idx, req1_idx;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       rf_we;
  logic [3:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic [1:0] cur_pa;
  logic       alu_stall;
  logic [7:0] wait_cnt;

  int checks   = 0;
  int failures = 0;

  logic [11:0] sb[$];
  logic        we_due = 1'b0;
  logic        exp_r0, exp_r1;
  logic        m_last;
  logic [1:0]  m_pa;

  rf_wr_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .set_pa     (set_pa),
    .req0_valid (req0_valid),
    .req0_idx   (req0_idx),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_idx   (req1_idx),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .cur_pa     (cur_pa),
    .alu_stall  (alu_stall),
    .wait_cnt   (wait_cnt)
  );

  always #5 clk = ~clk;

  // Write-port scoreboard: one cycle after each expected grant a matching write must appear.
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      checks++;
      if (rf_we !== we_due) begin
        failures++;
        $display("FAIL rf_we: got %b expected %b at %0t", rf_we, we_due, $time);
      end
      if (we_due) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_underflow: got write %h/%h expected none queued", rf_waddr, rf_wdata);
        end else begin
          logic [11:0] e;
          e = sb.pop_front();
          if ({rf_waddr, rf_wdata} !== e) begin
            failures++;
            $display("FAIL write: got addr=%h data=%h expected addr=%h data=%h",
                     rf_waddr, rf_wdata, e[11:8], e[7:0]);
          end
        end
      end
    end
    we_due = 1'b0;
  end

  // Drive one cycle of stimulus and advance the reference arbitration/PA model.
  task automatic drive(input logic v0, input logic [1:0] i0, input logic [7:0] d0,
                       input logic v1, input logic [1:0] i1, input logic [7:0] d1,
                       input logic [2:0] spa);
    logic [1:0] pe;
    logic g0, g1;
    @(negedge clk);
    req0_valid = v0; req0_idx = i0; req0_data = d0;
    req1_valid = v1; req1_idx = i1; req1_data = d1;
    set_pa = spa;
    #1;
    pe = spa[2] ? spa[1:0] : m_pa;
    g0 = v0 && (!v1 || m_last);
    g1 = v1 && !g0;
    exp_r0 = g0;
    exp_r1 = g1;
    if (g0) begin sb.push_back({pe, i0, d0}); m_last = 1'b0; end
    if (g1) begin sb.push_back({pe, i1, d1}); m_last = 1'b1; end
    we_due = g0 | g1;
    if (spa[2]) m_pa = spa[1:0];
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 3'b000);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; set_pa = 3'b000;
    sb.delete();
    we_due = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    m_last = 1'b1;
    m_pa = 2'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_pa = 3'b000;
    req0_valid = 1'b1; req0_idx = 2'd1; req0_data = 8'h11;
    req1_valid = 1'b1; req1_idx = 2'd2; req1_data = 8'h22;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL rst_we: got %b expected 0", rf_we); end
    checks++; if (rf_waddr !== 4'h0) begin failures++; $display("FAIL rst_waddr: got %h expected 0", rf_waddr); end
    checks++; if (rf_wdata !== 8'h00) begin failures++; $display("FAIL rst_wdata: got %h expected 00", rf_wdata); end
    checks++; if (cur_pa !== 2'd0) begin failures++; $display("FAIL rst_pa: got %0d expected 0", cur_pa); end
    checks++; if (wait_cnt !== 8'd0) begin failures++; $display("FAIL rst_wait: got %0d expected 0", wait_cnt); end
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin
      failures++; $display("FAIL rst_ready: got %b expected 00", {req0_ready, req1_ready});
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b0;
    m_last = 1'b1;
    m_pa = 2'd0;
  endtask

  task automatic test_single();
    drive(1'b1, 2'd2, 8'h5A, 1'b0, 2'd0, 8'h00, 3'b000);
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      failures++; $display("FAIL single_ready: got %b%b expected 10", req0_ready, req1_ready);
    end
    idle();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 4'h2 || rf_wdata !== 8'h5A) begin
      failures++; $display("FAIL single_write: got we=%b %h/%h expected 1 2/5a", rf_we, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_alternate();
    logic [3:0] exp_addr [4];
    logic [1:0] exp_rdy [4];
    exp_addr = '{4'h9, 4'hB, 4'h9, 4'hB};
    exp_rdy  = '{2'b01, 2'b10, 2'b01, 2'b10};
    pulse_reset();
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 3'b110);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'd1, 8'hA0, 1'b1, 2'd3, 8'hB0, 3'b000);
      checks++; if ({req1_ready, req0_ready} !== exp_rdy[k]) begin
        failures++; $display("FAIL alt_ready[%0d]: got %b expected %b", k, {req1_ready, req0_ready}, exp_rdy[k]);
      end
      checks++; if (alu_stall !== exp_rdy[k][1]) begin
        failures++; $display("FAIL alt_stall[%0d]: got %b expected %b", k, alu_stall, exp_rdy[k][1]);
      end
      if (k > 0) begin
        checks++; if (rf_waddr !== exp_addr[k-1]) begin
          failures++; $display("FAIL alt_addr[%0d]: got %h expected %h", k - 1, rf_waddr, exp_addr[k-1]);
        end
      end
    end
    idle();
    checks++; if (rf_waddr !== exp_addr[3]) begin
      failures++; $display("FAIL alt_addr[3]: got %h expected %h", rf_waddr, exp_addr[3]);
    end
    checks++; if (wait_cnt !== 8'd4) begin failures++; $display("FAIL alt_wait: got %0d expected 4", wait_cnt); end
  endtask

  task automatic test_pa_bypass();
    drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 8'h33, 3'b111);
    checks++; if (req1_ready !== 1'b1) begin failures++; $display("FAIL pa_ready: got %b expected 1", req1_ready); end
    idle();
    checks++; if (rf_waddr !== 4'hC) begin failures++; $display("FAIL pa_addr: got %h expected c", rf_waddr); end
    checks++; if (cur_pa !== 2'd3) begin failures++; $display("FAIL pa_cur: got %0d expected 3", cur_pa); end
  endtask

  task automatic test_same_dest();
    drive(1'b1, 2'd2, 8'hA1, 1'b1, 2'd2, 8'hB2, 3'b101);
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin
      failures++; $display("FAIL same_first: got %b expected 01", {req1_ready, req0_ready});
    end
    drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 8'hB2, 3'b000);
    checks++; if (req1_ready !== 1'b1) begin failures++; $display("FAIL same_second: got %b expected 1", req1_ready); end
    idle();
    checks++; if (rf_waddr !== 4'h6 || rf_wdata !== 8'hB2) begin
      failures++; $display("FAIL same_final: got %h/%h expected 6/b2", rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_reset_mid();
    checks++; if (wait_cnt !== 8'd5) begin failures++; $display("FAIL mid_wait_pre: got %0d expected 5", wait_cnt); end
    drive(1'b1, 2'd1, 8'h77, 1'b0, 2'd0, 8'h00, 3'b000);
    checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL mid_grant: got %b expected 1", req0_ready); end
    reset = 1'b1;
    sb.delete();
    we_due = 1'b0;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin
      failures++; $display("FAIL mid_ready: got %b expected 00", {req0_ready, req1_ready});
    end
    @(posedge clk);
    #1;
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL mid_we: got %b expected 0", rf_we); end
    checks++; if (cur_pa !== 2'd0) begin failures++; $display("FAIL mid_pa: got %0d expected 0", cur_pa); end
    checks++; if (wait_cnt !== 8'd0) begin failures++; $display("FAIL mid_wait: got %0d expected 0", wait_cnt); end
    @(negedge clk);
    reset = 1'b0;
    req0_valid = 1'b0;
    m_last = 1'b1;
    m_pa = 2'd0;
  endtask

  task automatic test_starvation();
    int g0 = 0, g1 = 0;
    logic [7:0] d0 = 8'h00, d1 = 8'h80;
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 2'd3, d0, 1'b1, 2'd1, d1, 3'b000);
      checks++; if ({req1_ready, req0_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        failures++; $display("FAIL starve_ready[%0d]: got %b", i, {req1_ready, req0_ready});
      end
      if (req0_ready) begin g0++; d0 = d0 + 8'd1; end
      if (req1_ready) begin g1++; d1 = d1 + 8'd1; end
    end
    idle();
    checks++; if (g0 !== 150 || g1 !== 150) begin
      failures++; $display("FAIL starve_counts: got %0d/%0d expected 150/150", g0, g1);
    end
    checks++; if (wait_cnt !== 8'd255) begin failures++; $display("FAIL starve_sat: got %0d expected 255", wait_cnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_pa_bypass();
    test_same_dest();
    test_reset_mid();
    test_starvation();
    idle();
    idle();
    checks++; if (sb.size() != 0) begin
      failures++; $display("FAIL sb_leftover: got %0d entries expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
